// File: rtl/trainer_logic_lab.sv
// Registered bitwise gate trainer: manual requests with a valid/ready output register,
// plus an optional 8-op sweep compiled in by TRAINER_LOGIC_LAB_SWEEP_EN.
module trainer_logic_lab #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       res_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             sweep_done
);

    // Handshake: a word moves on any edge where valid and ready are both high;
    // the output register holds result/res_op/out_valid until that edge.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       res_op_q, res_op_d;
    logic             out_valid_q, out_valid_d;
    logic             xfer;
    logic             start_take;

    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] sel,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        case (sel)
            3'd0:    gate_eval = x & y;
            3'd1:    gate_eval = x | y;
            3'd2:    gate_eval = x ^ y;
            3'd3:    gate_eval = ~(x & y);
            3'd4:    gate_eval = ~(x | y);
            3'd5:    gate_eval = ~(x ^ y);
            3'd6:    gate_eval = ~x;
            default: gate_eval = ~y;
        endcase
    endfunction

    assign xfer = out_valid_q && out_ready;

`ifdef TRAINER_LOGIC_LAB_SWEEP_EN
    logic [WIDTH-1:0] cap_a_q, cap_a_d;
    logic [WIDTH-1:0] cap_b_q, cap_b_d;
    logic [2:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             sweep_done_q, sweep_done_d;

    assign start_take = (state_q == IDLE) && start;
    assign busy       = (state_q == SWEEP);
    assign sweep_done = sweep_done_q;
`else
    logic sweep_unused;

    assign sweep_unused = start;
    assign start_take   = 1'b0;
    assign busy         = 1'b0;
    assign sweep_done   = 1'b0;
`endif

    // start wins over a simultaneous manual request.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !start_take;

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        res_op_d    = res_op_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            result_d    = gate_eval(op, a, b);
            res_op_d    = op;
            out_valid_d = 1'b1;
        end
`ifdef TRAINER_LOGIC_LAB_SWEEP_EN
        cap_a_d      = cap_a_q;
        cap_b_d      = cap_b_q;
        idx_d        = idx_q;
        last_d       = last_q;
        sweep_done_d = 1'b0;
        if (start_take) begin
            cap_a_d = a;
            cap_b_d = b;
            idx_d   = 3'd0;
            last_d  = 1'b0;
            state_d = SWEEP;
        end else if (state_q == SWEEP) begin
            // last_q marks that index 7 is loaded; finish once it drains.
            if (!last_q && (!out_valid_q || out_ready)) begin
                result_d    = gate_eval(idx_q, cap_a_q, cap_b_q);
                res_op_d    = idx_q;
                out_valid_d = 1'b1;
                idx_d       = idx_q + 3'd1;
                last_d      = (idx_q == 3'd7);
            end else if (last_q && xfer) begin
                state_d      = IDLE;
                last_d       = 1'b0;
                sweep_done_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            res_op_q    <= 3'd0;
            out_valid_q <= 1'b0;
`ifdef TRAINER_LOGIC_LAB_SWEEP_EN
            cap_a_q      <= '0;
            cap_b_q      <= '0;
            idx_q        <= 3'd0;
            last_q       <= 1'b0;
            sweep_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            res_op_q    <= res_op_d;
            out_valid_q <= out_valid_d;
`ifdef TRAINER_LOGIC_LAB_SWEEP_EN
            cap_a_q      <= cap_a_d;
            cap_b_q      <= cap_b_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            sweep_done_q <= sweep_done_d;
`endif
        end
    end

    assign result    = result_q;
    assign res_op    = res_op_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_trainer_logic_lab.sv
// Directed bench for trainer_logic_lab (WIDTH=4); sweep scenarios build only
// when TRAINER_LOGIC_LAB_SWEEP_EN is defined, macro-off scenarios otherwise.
module tb_trainer_logic_lab;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic             start;
    logic [WIDTH-1:0] result;
    logic [2:0]       res_op;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             sweep_done;

    int checks = 0;
    int errors = 0;

    // Hand-computed gate results for a=1100, b=1010, ops 0..7.
    logic [WIDTH-1:0] exp_tab [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                                      4'b0001, 4'b1001, 4'b0011, 4'b0101};

    trainer_logic_lab #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .start(start),
        .result(result), .res_op(res_op), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; a = '0; b = '0; op = 3'd0; in_valid = 1'b0;
        start = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %b exp 0", out_valid); errors++; end
        checks++; if (result !== 4'b0000) begin $display("FAIL reset_result got %b exp 0000", result); errors++; end
        checks++; if (res_op !== 3'd0) begin $display("FAIL reset_res_op got %0d exp 0", res_op); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", busy); errors++; end
        checks++; if (sweep_done !== 1'b0) begin $display("FAIL reset_done got %b exp 0", sweep_done); errors++; end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", in_ready); errors++; end
    endtask

    task automatic test_manual;
        a = 4'b1100; b = 4'b1010; op = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin $display("FAIL manual_valid got %b exp 1", out_valid); errors++; end
        checks++; if (result !== 4'b0110) begin $display("FAIL manual_result got %b exp 0110", result); errors++; end
        checks++; if (res_op !== 3'd2) begin $display("FAIL manual_res_op got %0d exp 2", res_op); errors++; end
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL manual_drain got %b exp 0", out_valid); errors++; end
    endtask

    task automatic test_all_ops;
        a = 4'b1100; b = 4'b1010; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k); in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== exp_tab[k] || res_op !== 3'(k)) begin
                $display("FAIL all_ops[%0d] got v=%b r=%b op=%0d exp v=1 r=%b op=%0d",
                         k, out_valid, result, res_op, exp_tab[k], k);
                errors++;
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL all_ops_drain got %b exp 0", out_valid); errors++; end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        a = 4'b1111; b = 4'b0101; op = 3'd0; in_valid = 1'b1;
        tick();
        a = 4'b0011; b = 4'b0100; op = 3'd1;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 4'b0101 || res_op !== 3'd0) begin
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b r=%b op=%0d exp rdy=0 v=1 r=0101 op=0",
                         c, in_ready, out_valid, result, res_op);
                errors++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready got %b exp 1", in_ready); errors++; end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 4'b0111 || res_op !== 3'd1) begin
            $display("FAIL bp_second got v=%b r=%b op=%0d exp v=1 r=0111 op=1", out_valid, result, res_op);
            errors++;
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL bp_drain got %b exp 0", out_valid); errors++; end
    endtask

`ifdef TRAINER_LOGIC_LAB_SWEEP_EN
    task automatic test_sweep;
        a = 4'b1100; b = 4'b1010; out_ready = 1'b1; op = 3'd3;
        start = 1'b1; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin $display("FAIL sweep_start_prio got %b exp 0", in_ready); errors++; end
        tick();
        start = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL sweep_enter got busy=%b v=%b exp busy=1 v=0", busy, out_valid); errors++; end
        tick();
        // Operand and start changes mid-sweep must not disturb the results.
        a = 4'b0000; b = 4'b1111; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== exp_tab[k] || res_op !== 3'(k) || busy !== 1'b1 || sweep_done !== 1'b0) begin
                $display("FAIL sweep[%0d] got v=%b r=%b op=%0d busy=%b done=%b exp v=1 r=%b op=%0d busy=1 done=0",
                         k, out_valid, result, res_op, busy, sweep_done, exp_tab[k], k);
                errors++;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (sweep_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL sweep_end got done=%b busy=%b v=%b exp done=1 busy=0 v=0", sweep_done, busy, out_valid);
            errors++;
        end
        tick();
        checks++; if (sweep_done !== 1'b0) begin $display("FAIL sweep_done_pulse got %b exp 0", sweep_done); errors++; end
    endtask

    task automatic test_sweep_stall;
        logic [WIDTH-1:0] prev_r;
        logic [2:0]       prev_op;
        logic             prev_held;
        int               n;
        bit               done_seen;
        n = 0; done_seen = 1'b0; prev_held = 1'b0; prev_r = '0; prev_op = 3'd0;
        a = 4'b1100; b = 4'b1010; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (sweep_done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                if (prev_held && (result !== prev_r || res_op !== prev_op || out_valid !== 1'b1)) begin
                    $display("FAIL stall_hold got v=%b r=%b op=%0d exp v=1 r=%b op=%0d",
                             out_valid, result, res_op, prev_r, prev_op);
                    errors++;
                end
                if (prev_held) checks++;
                if (out_valid && out_ready) begin
                    checks++;
                    if (n > 7 || result !== exp_tab[n & 7] || res_op !== 3'(n)) begin
                        $display("FAIL stall_seq[%0d] got r=%b op=%0d exp r=%b op=%0d",
                                 n, result, res_op, exp_tab[n & 7], n & 7);
                        errors++;
                    end
                    n++;
                end
                prev_held = out_valid && !out_ready;
                prev_r    = result;
                prev_op   = res_op;
                out_ready = ~out_ready;
                tick();
            end
        end
        out_ready = 1'b1;
        checks++; if (!done_seen || n != 8) begin
            $display("FAIL stall_count got done=%b n=%0d exp done=1 n=8", done_seen, n); errors++; end
        tick();
    endtask

    task automatic test_reset_mid_sweep;
        bit bad;
        a = 4'b1100; b = 4'b1010; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++; if (res_op !== 3'd2 || out_valid !== 1'b1) begin
            $display("FAIL mid_pre got op=%0d v=%b exp op=2 v=1", res_op, out_valid); errors++; end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 4'b0000 || busy !== 1'b0 || sweep_done !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL mid_reset got v=%b r=%b busy=%b done=%b rdy=%b exp v=0 r=0000 busy=0 done=0 rdy=1",
                     out_valid, result, busy, sweep_done, in_ready);
            errors++;
        end
        a = 4'b0110; b = 4'b0011; op = 3'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 4'b1000 || res_op !== 3'd4) begin
            $display("FAIL mid_manual got v=%b r=%b op=%0d exp v=1 r=1000 op=4", out_valid, result, res_op); errors++; end
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sweep_done !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin $display("FAIL mid_quiet got activity exp none"); errors++; end
    endtask
`else
    task automatic test_macro_off;
        bit bad;
        a = 4'b1100; b = 4'b1010; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (busy !== 1'b0 || out_valid !== 1'b0 || sweep_done !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++; if (bad) begin $display("FAIL off_start got activity exp none"); errors++; end
        a = 4'b0101; b = 4'b0011; op = 3'd7; in_valid = 1'b1; start = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin $display("FAIL off_ready got %b exp 1", in_ready); errors++; end
        tick();
        in_valid = 1'b0; start = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 4'b1100 || res_op !== 3'd7) begin
            $display("FAIL off_not_b got v=%b r=%b op=%0d exp v=1 r=1100 op=7", out_valid, result, res_op); errors++; end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_manual();
        test_all_ops();
        test_backpressure();
`ifdef TRAINER_LOGIC_LAB_SWEEP_EN
        test_sweep();
        test_sweep_stall();
        test_reset_mid_sweep();
`else
        test_macro_off();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
